mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single 64-bit memory bus between two requesters: the instruction-fetch stage (IF) and the load/store data-memory stage (DM).
- Bus is pipelined, with one address phase and one data phase per transfer, and wait states are inserted by HREADY.
- The block picks the address-phase owner each cycle, routes HRDATA back to the data-phase owner, and produces the fetch stall.
- Sits between the core pipeline and the memory/bus fabric.

Parameters:
- ADDR_W, 64, address width of all address ports.
- DATA_W, 64, data width of HRDATA/HWDATA and requester data ports.
- STARVE_MAX, 4, consecutive IF denials tolerated before a forced IF grant (only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req  in  1  IF wants a fetch this cycle.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  IF address phase accepted this cycle.
- if_rvalid  out  1  IF data phase complete; if_rdata valid.
- if_rdata  out  DATA_W  fetch read data, passthrough of HRDATA.
- if_stall  out  1  high when if_req=1 and if_gnt=0.
- dm_req  in  1  DM wants a transfer.
- dm_we  in  1  1 = store, 0 = load.
- dm_size  in  2  log2 of bytes (0 = byte … 3 = dword).
- dm_addr  in  ADDR_W  data address.
- dm_wdata  in  DATA_W  store data, sampled at grant.
- dm_gnt  out  1  DM address phase accepted.
- dm_rvalid  out  1  DM data phase complete; for loads dm_rdata is valid.
- dm_rdata  out  DATA_W  load data, passthrough of HRDATA.
- HADDR  out  ADDR_W  bus address.
- HTRANS  out  1  1 = valid transfer in address phase.
- HWRITE  out  1  bus write.
- HSIZE  out  2  bus size; IF transfers are always 2 (word).
- HWDATA  out  DATA_W  write data, driven in the data phase.
- HRDATA  in  DATA_W  bus read data.
- HREADY  in  1  data phase completes when 1.

Behaviour:
- Reset (synchronous, high at a posedge):
  - addr-phase and data-phase owner registers go to NONE.
  - HWDATA=0, starvation counter=0.
  - Outputs while in reset: HTRANS=0, all gnt/rvalid=0, HADDR=0, HWRITE=0, HSIZE=0.
  - An in-flight transfer is abandoned; no rvalid is issued for it.
- Data-phase owner register dp_own ∈ {NONE, IF, DM}, plus a dp_we flag.
- Address-phase arbitration is combinational, evaluated only when HREADY=1:
  - dm_req has priority over if_req (strict).
  - Winner: HTRANS=1; HADDR/HWRITE/HSIZE come from the winner; its gnt=1.
  - No request: HTRANS=0, HADDR holds its last registered value.
- HREADY=0:
  - no gnt is asserted; HADDR/HWRITE/HSIZE/HTRANS hold their registered values.
  - dp_own and HWDATA hold.
  - Nothing new enters.
- At posedge with HREADY=1: dp_own <= winner (or NONE); dp_we <= winner is DM and dm_we; if DM wins a store, HWDATA <= dm_wdata.
- rvalid is combinational: if_rvalid = HREADY & (dp_own==IF); dm_rvalid = HREADY & (dp_own==DM). rvalid is issued for stores too, as the completion signal.
- Latency: grant in cycle N, rvalid in cycle N+1 at zero wait states, or at the first cycle with HREADY=1 after N.
- Back-to-back: a new grant and the previous rvalid occur in the same cycle. Throughput is 1 transfer/cycle.
- Simultaneous if_req and dm_req: DM granted; if_stall=1.
- if_stall=0 whenever if_req=0.
- Requesters must hold req/addr stable until gnt.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- Defined:
  - Saturating counter starve_cnt (width clog2(STARVE_MAX+1)).
  - Increments each HREADY=1 cycle where if_req=1 and dm wins.
  - Clears on an IF grant or when if_req=0.
  - When starve_cnt==STARVE_MAX, IF wins over dm_req for that one cycle.
- Undefined: strict DM priority; the counter is absent.

Decomposition:
- Shared package mem_bus_pkg holds:
  - owner enum {OWN_NONE, OWN_IF, OWN_DM};
  - HSIZE constants SZ_B/SZ_H/SZ_W/SZ_D;
  - HTRANS_IDLE/HTRANS_NONSEQ (1-bit).
- Sub-module arb_prio2: 2-input fixed-priority picker with a force-low-priority input. Reused by the starvation guard.

Test Plan:
- Reset mid-transfer: grant IF at 0x1000, assert reset in the next cycle -> no if_rvalid; HTRANS=0, dp_own=NONE in the cycle after.
- IF only, HREADY=1: if_req at 0x0, 0x4, 0x8 consecutively -> if_gnt every cycle; if_rvalid one cycle after each grant, with if_rdata=HRDATA.
- Conflict: if_req=1 (0x2000) and dm_req=1 load at 0x8000 in the same cycle -> dm_gnt=1, if_stall=1, HADDR=0x8000; IF granted the next cycle.
- Store with wait states: dm_we=1, dm_addr=0x100, dm_wdata=0xDEADBEEF, HREADY=0 for 2 cycles -> HWDATA=0xDEADBEEF held throughout; dm_rvalid only when HREADY returns; no grants in between.
- Guard (macro on, STARVE_MAX=4): if_req and dm_req held high continuously -> IF granted in the 5th cycle; counter clears afterwards. With the macro off, IF is never granted.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared memory-bus definitions: transfer-owner encoding, HSIZE codes and HTRANS values.
package mem_bus_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    localparam logic HTRANS_IDLE   = 1'b0;
    localparam logic HTRANS_NONSEQ = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_prio2.sv
// Two-input fixed-priority picker; force_lo lets the low-priority side win for one cycle.
module arb_prio2 (
    input  logic req_hi,
    input  logic req_lo,
    input  logic force_lo,
    output logic gnt_hi,
    output logic gnt_lo
);

    assign gnt_lo = req_lo & (force_lo | ~req_hi);
    assign gnt_hi = req_hi & ~gnt_lo;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one pipelined 64-bit memory bus between instruction fetch (IF) and data memory (DM).
// Optional starvation guard for IF is enabled by defining MEM_ARB_STARVE_GUARD_EN.
//
//   dp_own   | meaning
//   ---------+---------------------------------------------------
//   OWN_NONE | no transfer in data phase
//   OWN_IF   | fetch in data phase; if_rvalid on next HREADY=1
//   OWN_DM   | load/store in data phase; dm_rvalid on next HREADY=1
module mem_port_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_stall,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [1:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] HADDR,
    output logic              HTRANS,
    output logic              HWRITE,
    output logic [1:0]        HSIZE,
    output logic [DATA_W-1:0] HWDATA,
    input  logic [DATA_W-1:0] HRDATA,
    input  logic              HREADY
);

    owner_e            dp_own, dp_own_nxt, win;
    logic [ADDR_W-1:0] haddr_q;
    logic              htrans_q;
    logic              hwrite_q;
    logic [1:0]        hsize_q;
    logic [DATA_W-1:0] hwdata_q;
    logic              arb_en;
    logic              force_if;
    logic              pick_if;
    logic              pick_dm;

    assign arb_en = HREADY & ~reset;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    logic [CNT_W-1:0] starve_cnt;

    assign force_if = (starve_cnt == CNT_W'(STARVE_MAX));

    always_ff @(posedge CLK) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (HREADY) begin
            if (!if_req || pick_if) begin
                starve_cnt <= '0;
            end else if (pick_dm && !force_if) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end
`else
    assign force_if = 1'b0;
`endif

    arb_prio2 u_prio (
        .req_hi   (dm_req & arb_en),
        .req_lo   (if_req & arb_en),
        .force_lo (force_if),
        .gnt_hi   (pick_dm),
        .gnt_lo   (pick_if)
    );

    always_comb begin
        win        = OWN_NONE;
        HTRANS     = htrans_q;
        HADDR      = haddr_q;
        HWRITE     = hwrite_q;
        HSIZE      = hsize_q;
        if_gnt     = 1'b0;
        dm_gnt     = 1'b0;
        if_rvalid  = 1'b0;
        dm_rvalid  = 1'b0;
        dp_own_nxt = dp_own;
        if (reset) begin
            HTRANS = HTRANS_IDLE;
            HADDR  = '0;
            HWRITE = 1'b0;
            HSIZE  = SZ_B;
        end else begin
            if (HREADY) begin
                HTRANS = HTRANS_IDLE;
                if (pick_dm) begin
                    win    = OWN_DM;
                    HTRANS = HTRANS_NONSEQ;
                    HADDR  = dm_addr;
                    HWRITE = dm_we;
                    HSIZE  = dm_size;
                    dm_gnt = 1'b1;
                end else if (pick_if) begin
                    win    = OWN_IF;
                    HTRANS = HTRANS_NONSEQ;
                    HADDR  = if_addr;
                    HWRITE = 1'b0;
                    HSIZE  = SZ_W;
                    if_gnt = 1'b1;
                end
                dp_own_nxt = win;
            end
            // Completion is tied to HREADY so a stalled data phase never reports early.
            if_rvalid = HREADY & (dp_own == OWN_IF);
            dm_rvalid = HREADY & (dp_own == OWN_DM);
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            dp_own   <= OWN_NONE;
            haddr_q  <= '0;
            htrans_q <= HTRANS_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= SZ_B;
            hwdata_q <= '0;
        end else if (HREADY) begin
            dp_own   <= dp_own_nxt;
            haddr_q  <= HADDR;
            htrans_q <= HTRANS;
            hwrite_q <= HWRITE;
            hsize_q  <= HSIZE;
            if (win == OWN_DM && dm_we) begin
                hwdata_q <= dm_wdata;
            end
        end
    end

    assign if_stall = if_req & ~if_gnt;
    assign if_rdata = HRDATA;
    assign dm_rdata = HRDATA;
    assign HWDATA   = hwdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized traffic vs. a reference model.
module tb_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        CLK;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic        if_gnt, if_rvalid, if_stall;
    logic [63:0] if_rdata;
    logic        dm_req, dm_we;
    logic [1:0]  dm_size;
    logic [63:0] dm_addr, dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [63:0] dm_rdata;
    logic [63:0] HADDR, HWDATA, HRDATA;
    logic        HTRANS, HWRITE, HREADY;
    logic [1:0]  HSIZE;

    mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(STARVE_MAX)) dut (
        .CLK(CLK), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_stall(if_stall),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who owns the pending data phase (0 none, 1 IF, 2 DM),
    // last bus address-phase values presented on a ready cycle, and the store data latch.
    int          pend = 0;
    logic [63:0] last_addr = '0;
    logic        last_write = 1'b0;
    logic [1:0]  last_size = 2'd0;
    logic        last_trans = 1'b0;
    logic [63:0] m_hwdata = '0;
`ifdef MEM_ARB_STARVE_GUARD_EN
    int          starve = 0;
`endif
    int          last_win = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int exp_win();
        bit if_first;
        if (reset || !HREADY) return 0;
        if_first = !dm_req;
`ifdef MEM_ARB_STARVE_GUARD_EN
        if (starve == STARVE_MAX) if_first = 1'b1;
`endif
        if (if_req && if_first) return 1;
        if (dm_req) return 2;
        return 0;
    endfunction

    task automatic sample();
        int          w;
        logic        e_trans, e_write, e_ifrv, e_dmrv;
        logic [63:0] e_addr;
        logic [1:0]  e_size;
        @(negedge CLK);
        w = exp_win();
        e_ifrv = !reset && HREADY && pend == 1;
        e_dmrv = !reset && HREADY && pend == 2;
        if (reset) begin
            e_trans = 1'b0; e_addr = '0; e_write = 1'b0; e_size = 2'd0;
        end else if (!HREADY) begin
            e_trans = last_trans; e_addr = last_addr; e_write = last_write; e_size = last_size;
        end else if (w == 2) begin
            e_trans = 1'b1; e_addr = dm_addr; e_write = dm_we; e_size = dm_size;
        end else if (w == 1) begin
            e_trans = 1'b1; e_addr = if_addr; e_write = 1'b0; e_size = 2'd2;
        end else begin
            e_trans = 1'b0; e_addr = last_addr; e_write = last_write; e_size = last_size;
        end
        chk("if_gnt",    64'(if_gnt),    64'(w == 1));
        chk("dm_gnt",    64'(dm_gnt),    64'(w == 2));
        chk("if_stall",  64'(if_stall),  64'(if_req && w != 1));
        chk("if_rvalid", 64'(if_rvalid), 64'(e_ifrv));
        chk("dm_rvalid", 64'(dm_rvalid), 64'(e_dmrv));
        chk("HTRANS",    64'(HTRANS),    64'(e_trans));
        chk("HADDR",     HADDR,          e_addr);
        chk("HWRITE",    64'(HWRITE),    64'(e_write));
        chk("HSIZE",     64'(HSIZE),     64'(e_size));
        chk("HWDATA",    HWDATA,         m_hwdata);
        if (e_ifrv) chk("if_rdata", if_rdata, HRDATA);
        if (e_dmrv) chk("dm_rdata", dm_rdata, HRDATA);
    endtask

    task automatic advance();
        int w;
        @(posedge CLK);
        w = exp_win();
        last_win = w;
        if (reset) begin
            pend = 0; m_hwdata = '0; last_addr = '0; last_write = 1'b0;
            last_size = 2'd0; last_trans = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            starve = 0;
`endif
        end else if (HREADY) begin
            pend = w;
            last_trans = (w != 0);
            if (w == 2) begin
                last_addr = dm_addr; last_write = dm_we; last_size = dm_size;
                if (dm_we) m_hwdata = dm_wdata;
            end else if (w == 1) begin
                last_addr = if_addr; last_write = 1'b0; last_size = 2'd2;
            end
`ifdef MEM_ARB_STARVE_GUARD_EN
            if (!if_req || w == 1) starve = 0;
            else if (w == 2 && starve < STARVE_MAX) starve++;
`endif
        end
        #1;
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    initial begin
        logic exp_g;
        reset = 1'b1; if_req = 1'b0; if_addr = '0; dm_req = 1'b0; dm_we = 1'b0;
        dm_size = 2'd0; dm_addr = '0; dm_wdata = '0; HRDATA = '0; HREADY = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
        cyc();

        // Reset in the cycle after an IF grant abandons the fetch.
        if_req = 1'b1; if_addr = 64'h1000;
        sample(); chk("rst_if_gnt", 64'(if_gnt), 64'd1); advance();
        if_req = 1'b0; reset = 1'b1;
        sample(); chk("rst_no_rvalid", 64'(if_rvalid), 64'd0); advance();
        reset = 1'b0;
        sample(); chk("rst_after_rvalid", 64'(if_rvalid), 64'd0);
        chk("rst_after_htrans", 64'(HTRANS), 64'd0); advance();

        // IF-only back-to-back fetches.
        for (int k = 0; k < 4; k++) begin
            if_req = (k < 3); if_addr = 64'(k * 4);
            HRDATA = {$urandom, $urandom};
            sample();
            if (k < 3) chk("if_b2b_gnt", 64'(if_gnt), 64'd1);
            if (k > 0) begin
                chk("if_b2b_rvalid", 64'(if_rvalid), 64'd1);
                chk("if_b2b_rdata", if_rdata, HRDATA);
            end
            advance();
        end

        // Simultaneous requests: DM load wins, IF follows.
        if_req = 1'b1; if_addr = 64'h2000; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h8000; dm_size = 2'd3;
        sample(); chk("conf_dm_gnt", 64'(dm_gnt), 64'd1); chk("conf_stall", 64'(if_stall), 64'd1);
        chk("conf_haddr", HADDR, 64'h8000); advance();
        dm_req = 1'b0;
        sample(); chk("conf_if_gnt", 64'(if_gnt), 64'd1); chk("conf_haddr2", HADDR, 64'h2000); advance();
        if_req = 1'b0;
        cyc();

        // Store with two wait states; a fetch waits behind it.
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 2'd3; dm_addr = 64'h100; dm_wdata = 64'hDEADBEEF;
        sample(); chk("st_gnt", 64'(dm_gnt), 64'd1); advance();
        dm_req = 1'b0; dm_wdata = '0; if_req = 1'b1; if_addr = 64'h3000; HREADY = 1'b0;
        for (int k = 0; k < 2; k++) begin
            sample();
            chk("st_wait_hwdata", HWDATA, 64'hDEADBEEF);
            chk("st_wait_rvalid", 64'(dm_rvalid), 64'd0);
            chk("st_wait_gnt", 64'(if_gnt | dm_gnt), 64'd0);
            advance();
        end
        HREADY = 1'b1;
        sample(); chk("st_done_rvalid", 64'(dm_rvalid), 64'd1); chk("st_done_hwdata", HWDATA, 64'hDEADBEEF);
        chk("st_if_gnt", 64'(if_gnt), 64'd1); advance();
        if_req = 1'b0;
        cyc();

        // Continuous contention: guard grants IF on the 5th cycle, otherwise never.
        if_req = 1'b1; if_addr = 64'h4000; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 64'h5000;
        for (int k = 0; k < 7; k++) begin
            sample();
`ifdef MEM_ARB_STARVE_GUARD_EN
            exp_g = (k == 4);
`else
            exp_g = 1'b0;
`endif
            chk("guard_if_gnt", 64'(if_gnt), 64'(exp_g));
            advance();
        end
        if_req = 1'b0; dm_req = 1'b0;
        cyc();

        // Randomized traffic; requesters hold req/addr until granted.
        for (int n = 0; n < 3000; n++) begin
            if (!if_req || last_win == 1) begin
                if_req  = ($urandom_range(0, 99) < 60);
                if_addr = {$urandom, $urandom} & ~64'h3;
            end
            if (!dm_req || last_win == 2) begin
                dm_req   = ($urandom_range(0, 99) < 50);
                dm_we    = $urandom_range(0, 1) == 1;
                dm_size  = 2'($urandom_range(0, 3));
                dm_addr  = {$urandom, $urandom};
                dm_wdata = {$urandom, $urandom};
            end
            HREADY = ($urandom_range(0, 3) != 0);
            HRDATA = {$urandom, $urandom};
            reset  = ($urandom_range(0, 63) == 0);
            cyc();
        end

        reset = 1'b0; if_req = 1'b0; dm_req = 1'b0; HREADY = 1'b1;
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
